// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter transmitter: state encoding,
// letter pattern/length lookup and default unit timing.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_DOT_UNITS    = 1;
    localparam int unsigned DEF_DASH_UNITS   = 3;
    localparam int unsigned DEF_GAP_UNITS    = 1;
    localparam int unsigned LETTER_GAP_UNITS = 3;

    // Dot/dash pattern per letter, sent LSB first, 1 = dash.
    function automatic logic [3:0] letter_pattern(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b0010; // A .-
            3'd1:    pat = 4'b0001; // B -...
            3'd2:    pat = 4'b0101; // C -.-.
            3'd3:    pat = 4'b0001; // D -..
            3'd4:    pat = 4'b0000; // E .
            3'd5:    pat = 4'b0100; // F ..-.
            3'd6:    pat = 4'b0011; // G --.
            default: pat = 4'b0000; // H ....
        endcase
        return pat;
    endfunction

    // Number of marks per letter.
    function automatic logic [2:0] letter_len(input logic [2:0] idx);
        logic [2:0] len;
        case (idx)
            3'd0:    len = 3'd2;
            3'd1:    len = 3'd4;
            3'd2:    len = 3'd4;
            3'd3:    len = 3'd3;
            3'd4:    len = 3'd1;
            3'd5:    len = 3'd4;
            3'd6:    len = 3'd3;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Unit-time tick generator: pulses unit_tick for one cycle every TICK_DIV
// cycles, counted from the last cycle clr was high.
module morse_tick_gen #(
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic unit_tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign unit_tick = (cnt_q == CNT_LAST);

    // Next count: restart on clr, wrap at the end of each unit.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || unit_tick) begin
            cnt_d = '0;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_tx_ctrl.sv
// Morse letter sequencer (A-H): latches a letter on start, then drives
// tx_out through its marks and intra-letter gaps in unit-time steps.
// Optional feature macro: MORSE_LETTER_GAP_EN adds a 3-unit inter-letter
// gap after the final mark, before the done pulse.
module morse_tx_ctrl
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned DOT_UNITS  = DEF_DOT_UNITS,
    parameter int unsigned DASH_UNITS = DEF_DASH_UNITS,
    parameter int unsigned GAP_UNITS  = DEF_GAP_UNITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] letter,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAX_U = max_u(max_u(DOT_UNITS, DASH_UNITS),
                                          max_u(GAP_UNITS, LETTER_GAP_UNITS));
    localparam int unsigned UW = (MAX_U > 2) ? $clog2(MAX_U) : 1;

    localparam logic [UW-1:0] DOT_LAST  = UW'(DOT_UNITS - 1);
    localparam logic [UW-1:0] DASH_LAST = UW'(DASH_UNITS - 1);
    localparam logic [UW-1:0] GAP_LAST  = UW'(GAP_UNITS - 1);
    localparam logic [UW-1:0] LGAP_LAST = UW'(LETTER_GAP_UNITS - 1);

    state_e        state_q, state_d;
    logic [3:0]    pat_q, pat_d;
    logic [2:0]    rem_q, rem_d;
    logic [UW-1:0] units_q, units_d;
    logic          unit_tick;
    logic          clr;
    logic [UW-1:0] mark_last;
    logic [UW-1:0] gap_last;

    // A gap with no marks remaining is the inter-letter gap.
    assign mark_last = pat_q[0] ? DASH_LAST : DOT_LAST;
    assign gap_last  = (rem_q == 3'd0) ? LGAP_LAST : GAP_LAST;

    // Restart unit timing on every state entry, and hold it idle in IDLE.
    assign clr = (state_d != state_q) || (state_q == IDLE);

    morse_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .unit_tick (unit_tick)
    );

    // Next-state logic: letter latch, per-state unit counting, pattern shift.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        units_d = units_q;
        case (state_q)
            IDLE: begin
                units_d = '0;
                if (start) begin
                    pat_d   = letter_pattern(letter);
                    rem_d   = letter_len(letter);
                    state_d = MARK;
                end
            end
            MARK: begin
                if (unit_tick) begin
                    if (units_q == mark_last) begin
                        units_d = '0;
                        pat_d   = pat_q >> 1;
                        rem_d   = rem_q - 3'd1;
                        if (rem_q == 3'd1) begin
`ifdef MORSE_LETTER_GAP_EN
                            state_d = GAP;
`else
                            state_d = DONE;
`endif
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        units_d = units_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (unit_tick) begin
                    if (units_q == gap_last) begin
                        units_d = '0;
                        state_d = (rem_q == 3'd0) ? DONE : MARK;
                    end else begin
                        units_d = units_q + 1'b1;
                    end
                end
            end
            default: begin
                units_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rem_q   <= '0;
            units_q <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            units_q <= units_d;
        end
    end

    // Outputs decoded from state only.
    always_comb begin
        tx_out = (state_q == MARK);
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
    end

endmodule

// File: tb/tb_morse_tx_ctrl.sv
// Bench for morse_tx_ctrl with TICK_DIV=4: table of letters plus hand
// sequences for held start, mid-letter reset and ignored inputs while busy.
module tb_morse_tx_ctrl;

    localparam int TD = 4;
`ifdef MORSE_LETTER_GAP_EN
    localparam int LG = 3 * TD;
`else
    localparam int LG = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] letter;
    logic       tx_out;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    morse_tx_ctrl #(
        .TICK_DIV   (TD),
        .DOT_UNITS  (1),
        .DASH_UNITS (3),
        .GAP_UNITS  (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .letter (letter),
        .tx_out (tx_out),
        .busy   (busy),
        .done   (done)
    );

    typedef struct packed {
        logic tx;
        logic bsy;
        logic dn;
    } obs_t;

    typedef struct {
        logic [2:0] l;
        logic [3:0] pat;
        int         len;
        int         done_cyc;
    } vec_t;

    obs_t sb_q[$];
    obs_t mon_e;
    vec_t vecs[8];
    int   checks   = 0;
    int   failures = 0;
    int   mon_cyc  = 0;
    int   obs_done = -1;

    // Monitor: one expected cycle popped and compared per falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_cyc++;
            checks++;
            if ({tx_out, busy, done} !== mon_e) begin
                failures++;
                $display("FAIL trace cyc=%0d tx/busy/done got=%b%b%b exp=%b%b%b",
                         mon_cyc, tx_out, busy, done, mon_e.tx, mon_e.bsy, mon_e.dn);
            end
            if (done === 1'b1 && obs_done < 0) obs_done = mon_cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic push_n(input obs_t v, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(v);
    endtask

    // Reference trace of one letter: marks, intra gaps, optional letter gap, done.
    task automatic push_letter(input logic [3:0] pat, input int len);
        for (int i = 0; i < len; i++) begin
            push_n(3'b110, pat[i] ? 3 * TD : TD);
            if (i < len - 1) push_n(3'b010, TD);
        end
        if (LG > 0) push_n(3'b010, LG);
        push_n(3'b011, 1);
    endtask

    // Drive start ahead of edge 0; return just after edge 0.
    task automatic start_letter(input logic [2:0] l, input bit hold);
        @(negedge clk);
        letter = l;
        start  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        mon_cyc  = 0;
        obs_done = -1;
    endtask

    // Wait for the scoreboard to empty; optionally pulse start with letter E
    // so that it is sampled at edge disturb_at.
    task automatic drain(input int disturb_at);
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < 500) begin
            @(posedge clk);
            k++;
            if (disturb_at > 0 && mon_cyc == disturb_at - 1) begin
                #1;
                letter = 3'd4;
                start  = 1'b1;
            end else if (disturb_at > 0 && mon_cyc == disturb_at) begin
                #1;
                start = 1'b0;
            end
        end
        chk("drain_left", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int k;
        vecs[0] = '{3'd4, 4'b0000, 1, 5};
        vecs[1] = '{3'd0, 4'b0010, 2, 21};
        vecs[2] = '{3'd1, 4'b0001, 4, 37};
        vecs[3] = '{3'd2, 4'b0101, 4, 45};
        vecs[4] = '{3'd3, 4'b0001, 3, 29};
        vecs[5] = '{3'd5, 4'b0100, 4, 37};
        vecs[6] = '{3'd6, 4'b0011, 3, 37};
        vecs[7] = '{3'd7, 4'b0000, 4, 29};

        reset  = 1'b0;
        start  = 1'b0;
        letter = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", int'(tx_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Every letter once, single-cycle start pulse.
        for (int i = 0; i < 8; i++) begin
            start_letter(vecs[i].l, 1'b0);
            push_letter(vecs[i].pat, vecs[i].len);
            push_n(3'b000, 1);
            drain(0);
            chk($sformatf("done_cyc_letter%0d", vecs[i].l), obs_done, vecs[i].done_cyc + LG);
        end

        // H with start held: second H begins two cycles after the done pulse.
        start_letter(3'd7, 1'b1);
        push_letter(4'b0000, 4);
        push_n(3'b000, 1);
        push_n(3'b110, TD);
        drain(0);
        chk("held_done_cyc", obs_done, 29 + LG);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("held_reset_tx", int'(tx_out), 0);
        chk("held_reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;

        // B aborted by reset during cycle 10.
        start_letter(3'd1, 1'b0);
        push_letter(4'b0001, 4);
        k = 0;
        while (mon_cyc < 9 && k < 100) begin
            @(posedge clk);
            k++;
        end
        chk("abort_reached_cyc9", mon_cyc, 9);
        sb_q.delete();
        #2;
        reset = 1'b0;
        #1;
        chk("abort_tx", int'(tx_out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_cyc = 0;
        push_n(3'b000, 6);
        drain(0);
        chk("abort_no_done", obs_done, -1);

        // C with letter change and start pulse at cycle 6: both ignored.
        @(negedge clk);
        start_letter(3'd2, 1'b0);
        push_letter(4'b0101, 4);
        push_n(3'b000, 1);
        drain(6);
        chk("busy_ignore_done_cyc", obs_done, 45 + LG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
